play_session: RTL

PLAY_SESSION -- requirements
Module: play_session

---
 rtl/play_pkg.sv | 33 +++
 rtl/play_judge.sv | 47 ++++
 rtl/play_session.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/play_pkg.sv
// ============================================================================
//  Module   : play_pkg
//  Brief    : Shared FSM states, judgement codes, speed encodings and points
//  Revision : 1.0
// ============================================================================
`default_nettype none

package play_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_HIT = 3'd2,
    S_JUDGE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] c_JUDGE_NONE    = 2'b00;
  localparam logic [1:0] c_JUDGE_MISS    = 2'b01;
  localparam logic [1:0] c_JUDGE_GOOD    = 2'b10;
  localparam logic [1:0] c_JUDGE_PERFECT = 2'b11;

  localparam logic [1:0] c_SPEED_NORMAL     = 2'b00;
  localparam logic [1:0] c_SPEED_NORMAL_ALT = 2'b01;
  localparam logic [1:0] c_SPEED_HALF       = 2'b10;
  localparam logic [1:0] c_SPEED_DOUBLE     = 2'b11;

  localparam logic [1:0] c_PTS_PERFECT = 2'd3;
  localparam logic [1:0] c_PTS_GOOD    = 2'd1;

endpackage

`default_nettype wire

// File: rtl/play_judge.sv
// ============================================================================
//  Module   : play_judge
//  Brief    : Combinational judgement of a hit against the goal note/window
//  Revision : 1.0
// ============================================================================
`default_nettype none

module play_judge
  import play_pkg::*;
#(
  parameter int LEN_W = 24
) (
  input  logic             i_hit,
  input  logic [2:0]       i_hit_note,
  input  logic [2:0]       i_hit_octave,
  input  logic [2:0]       i_goal_note,
  input  logic [2:0]       i_goal_octave,
  input  logic [LEN_W-1:0] i_window,
  input  logic [LEN_W-1:0] i_win_load,
  output logic [1:0]       o_judge,
  output logic [1:0]       o_pts
);

  logic w_match;
  logic w_early;

  assign w_match = (i_hit_note == i_goal_note) && (i_hit_octave == i_goal_octave);
  // Early half of the window (inclusive of the midpoint) earns PERFECT.
  assign w_early = (i_window >= (i_win_load >> 1));

  always_comb begin
    o_judge = c_JUDGE_MISS;
    o_pts   = '0;
    if (i_hit && w_match) begin
      if (w_early) begin
        o_judge = c_JUDGE_PERFECT;
        o_pts   = c_PTS_PERFECT;
      end else begin
        o_judge = c_JUDGE_GOOD;
        o_pts   = c_PTS_GOOD;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/play_session.sv
// ============================================================================
//  Module   : play_session
//  Brief    : Rhythm-game session FSM: note fetch, hit window, scoring, combo.
//             Optional per-user high-score table: PLAY_SESSION_HISCORE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module play_session
  import play_pkg::*;
#(
  parameter int NUM_USERS    = 8,
  parameter int SCORE_W      = 21,
  parameter int LEN_W        = 24,
  parameter int IDX_W        = 8,
  parameter int BONUS_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_start,
  input  logic                         i_hit_valid,
  input  logic [2:0]                   i_hit_note,
  input  logic [2:0]                   i_hit_octave,
  input  logic [IDX_W-1:0]             i_song_len,
  output logic [IDX_W-1:0]             o_note_idx,
  input  logic [2:0]                   i_goal_note,
  input  logic [2:0]                   i_goal_octave,
  input  logic [LEN_W-1:0]             i_goal_len,
  input  logic [$clog2(NUM_USERS)-1:0] i_user_sel,
  input  logic [1:0]                   i_speed_mod,
  output logic [6:0]                   o_note_led,
  output logic                         o_sound_go,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [1:0]                   o_judge,
  output logic [SCORE_W-1:0]           o_score,
  output logic [SCORE_W-1:0]           o_combo,
  output logic [SCORE_W-1:0]           o_max_combo,
  output logic [SCORE_W-1:0]           o_best_score
);

  localparam int UW = $clog2(NUM_USERS);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_note_idx, r_song_len;
  logic [SCORE_W-1:0] r_score, r_combo, r_max_combo;
  logic [1:0]         r_judge, r_pts, r_speed;
  logic [LEN_W-1:0]   r_window, r_win_load;
  logic               r_sound_go, r_done;

  logic [LEN_W-1:0]   w_win_init, w_len_half;
  logic               w_expire, w_last, w_bonus;
  logic [1:0]         w_judge, w_pts;
  logic [SCORE_W-1:0] w_combo_inc, w_add, w_score_sat;
  logic [SCORE_W:0]   w_sum;
  logic [7:0]         w_led_wide;

  play_judge #(.LEN_W(LEN_W)) u_judge (
    .i_hit         (i_hit_valid),
    .i_hit_note    (i_hit_note),
    .i_hit_octave  (i_hit_octave),
    .i_goal_note   (i_goal_note),
    .i_goal_octave (i_goal_octave),
    .i_window      (r_window),
    .i_win_load    (r_win_load),
    .o_judge       (w_judge),
    .o_pts         (w_pts)
  );

  assign w_expire = (r_window < LEN_W'(2));
  assign w_last   = ((r_note_idx + IDX_W'(1)) == r_song_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (i_start) w_next = (i_song_len != '0) ? S_FETCH : S_DONE;
        S_FETCH:    w_next = S_WAIT_HIT;
        S_WAIT_HIT: if (i_hit_valid || w_expire) w_next = S_JUDGE;
        S_JUDGE:    w_next = w_last ? S_DONE : S_FETCH;
        S_DONE:     w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  assign w_len_half = i_goal_len >> 1;

  always_comb begin
    w_win_init = i_goal_len;
    case (r_speed)
      c_SPEED_NORMAL, c_SPEED_NORMAL_ALT: w_win_init = i_goal_len;
      c_SPEED_HALF:   w_win_init = i_goal_len[LEN_W-1] ? '1 : {i_goal_len[LEN_W-2:0], 1'b0};
      c_SPEED_DOUBLE: w_win_init = (w_len_half == '0) ? LEN_W'(1) : w_len_half;
      default:        w_win_init = i_goal_len;
    endcase
  end

  // Bonus is judged on the combo value after this hit is counted.
  assign w_combo_inc = (r_combo == '1) ? r_combo : r_combo + SCORE_W'(1);
  assign w_bonus     = (w_combo_inc >= SCORE_W'(BONUS_THRESH));
  assign w_add       = {{(SCORE_W-2){1'b0}}, r_pts} + SCORE_W'(w_bonus);
  assign w_sum       = {1'b0, r_score} + {1'b0, w_add};
  assign w_score_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_note_idx  <= '0;
      r_song_len  <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_judge     <= c_JUDGE_NONE;
      r_pts       <= '0;
      r_speed     <= '0;
      r_window    <= '0;
      r_win_load  <= '0;
      r_sound_go  <= 1'b0;
      r_done      <= 1'b0;
    end else if (!i_en) begin
      r_note_idx  <= '0;
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_judge     <= c_JUDGE_NONE;
      r_pts       <= '0;
      r_window    <= '0;
      r_sound_go  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sound_go <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_note_idx  <= '0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_judge     <= c_JUDGE_NONE;
            r_song_len  <= i_song_len;
            r_speed     <= i_speed_mod;
          end
        end
        S_FETCH: begin
          r_window   <= w_win_init;
          r_win_load <= w_win_init;
        end
        S_WAIT_HIT: begin
          if (i_hit_valid || w_expire) begin
            r_judge    <= w_judge;
            r_pts      <= w_pts;
            r_sound_go <= (w_judge != c_JUDGE_MISS);
          end
          if (r_window != '0) r_window <= r_window - LEN_W'(1);
        end
        S_JUDGE: begin
          r_note_idx <= r_note_idx + IDX_W'(1);
          if (r_judge != c_JUDGE_MISS) begin
            r_combo <= w_combo_inc;
            r_score <= w_score_sat;
            if (w_combo_inc > r_max_combo) r_max_combo <= w_combo_inc;
          end else begin
            r_combo <= '0;
          end
        end
        S_DONE:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PLAY_SESSION_HISCORE_EN
  logic [SCORE_W-1:0] r_hi [NUM_USERS];
  logic [UW-1:0]      r_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) r_hi[i] <= '0;
      r_user <= '0;
    end else if (i_en) begin
      if (r_state == S_IDLE && i_start) r_user <= i_user_sel;
      if (r_state == S_DONE && r_score > r_hi[r_user]) r_hi[r_user] <= r_score;
    end
  end

  assign o_best_score = r_hi[r_user];
`else
  logic w_unused_user;
  assign w_unused_user = ^i_user_sel;
  assign o_best_score  = '0;
`endif

  assign w_led_wide  = 8'd1 << i_goal_note;
  assign o_note_led  = (r_state == S_WAIT_HIT) ? w_led_wide[7:1] : 7'd0;
  assign o_note_idx  = r_note_idx;
  assign o_score     = r_score;
  assign o_combo     = r_combo;
  assign o_max_combo = r_max_combo;
  assign o_judge     = r_judge;
  assign o_sound_go  = r_sound_go;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
